// File: rtl/reorder_queue.sv
// rtl/reorder_queue.sv - in-order allocate, out-of-order fill, in-order retire queue
// One-hot head/tail pointers; multi-port fill by token with optional head bypass.
module reorder_queue #(
    parameter int HDR_WID     = 32,
    parameter int DATA_WID    = 32,
    parameter int DEPTH       = 4,
    parameter int FILL_PORTS  = 2,
    parameter int TAG_WID     = 4,
    parameter int FILL_BYPASS = 1
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           alloc_valid,
    input  logic [HDR_WID-1:0]             alloc_hdr,
    output logic                           alloc_ready,
    output logic [DEPTH-1:0]               alloc_tok,
    input  logic [FILL_PORTS-1:0]          fill_valid,
    input  logic [FILL_PORTS*DEPTH-1:0]    fill_tok,
    input  logic [FILL_PORTS*DATA_WID-1:0] fill_data,
    output logic                           out_valid,
    output logic [HDR_WID-1:0]             out_hdr,
    output logic [DATA_WID-1:0]            out_data,
    input  logic                           out_ready,
    input  logic                           flush,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    input  logic [TAG_WID-1:0]             det_tag,
    output logic                           hazard
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0]    head, tail, allocd, filled;
    logic [DEPTH-1:0]    allocd_nxt, filled_nxt;
    logic [CW-1:0]       cnt;
    logic [HDR_WID-1:0]  hdr_mem  [DEPTH];
    logic [DATA_WID-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]    hit;
    logic [DATA_WID-1:0] hit_data [DEPTH];
    logic [IW-1:0]       head_idx;
    logic                head_filled, head_hit, alloc_fire, retire_fire;

    // Ports scanned high to low so the lowest-index port wins a shared token.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_data[i] = '0;
            for (int p = FILL_PORTS-1; p >= 0; p--) begin
                if (fill_valid[p] && fill_tok[p*DEPTH+i] && allocd[i] && !filled[i]) begin
                    hit[i]      = 1'b1;
                    hit_data[i] = fill_data[p*DATA_WID +: DATA_WID];
                end
            end
        end
    end

    always_comb begin
        head_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (head[i]) head_idx = IW'(i);
        end
    end

    assign head_filled = |(head & filled);
    assign head_hit    = (FILL_BYPASS != 0) && |(head & hit);
    assign out_valid   = !flush && |(head & allocd) && (head_filled || head_hit);
    assign out_hdr     = hdr_mem[head_idx];
    assign out_data    = head_filled ? data_mem[head_idx] : hit_data[head_idx];
    assign retire_fire = out_valid && out_ready;
    assign alloc_ready = !flush && ((cnt < CW'(DEPTH)) || retire_fire);
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tok   = tail;
    assign count       = cnt;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (allocd[i] && hdr_mem[i][TAG_WID-1:0] == det_tag && !(head[i] && retire_fire))
                hazard = 1'b1;
        end
    end

    // Allocation is applied last so a reused entry always starts unfilled.
    always_comb begin
        allocd_nxt = allocd;
        filled_nxt = filled | hit;
        if (retire_fire) begin
            allocd_nxt = allocd_nxt & ~head;
            filled_nxt = filled_nxt & ~head;
        end
        if (alloc_fire) begin
            allocd_nxt = allocd_nxt | tail;
            filled_nxt = filled_nxt & ~tail;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            head   <= DEPTH'(1);
            tail   <= DEPTH'(1);
            allocd <= '0;
            filled <= '0;
            cnt    <= '0;
        end else begin
            allocd <= allocd_nxt;
            filled <= filled_nxt;
            if (retire_fire) head <= {head[DEPTH-2:0], head[DEPTH-1]};
            if (alloc_fire)  tail <= {tail[DEPTH-2:0], tail[DEPTH-1]};
            case ({alloc_fire, retire_fire})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (hit[i] && !flush)         data_mem[i] <= hit_data[i];
            if (alloc_fire && tail[i])    hdr_mem[i]  <= alloc_hdr;
        end
    end
endmodule

// File: tb/tb_reorder_queue.sv
// tb/tb_reorder_queue.sv - directed self-checking bench for reorder_queue
module tb_reorder_queue;
    logic        clk = 1'b0;
    logic        resetn, alloc_valid, alloc_ready, out_valid, out_ready, flush, hazard;
    logic [31:0] alloc_hdr, out_hdr, out_data;
    logic [3:0]  alloc_tok, det_tag;
    logic [1:0]  fill_valid;
    logic [7:0]  fill_tok;
    logic [63:0] fill_data;
    logic [2:0]  count;
    int n_cmp = 0;
    int n_err = 0;

    reorder_queue dut (
        .clk(clk), .resetn(resetn),
        .alloc_valid(alloc_valid), .alloc_hdr(alloc_hdr), .alloc_ready(alloc_ready), .alloc_tok(alloc_tok),
        .fill_valid(fill_valid), .fill_tok(fill_tok), .fill_data(fill_data),
        .out_valid(out_valid), .out_hdr(out_hdr), .out_data(out_data), .out_ready(out_ready),
        .flush(flush), .count(count), .det_tag(det_tag), .hazard(hazard)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0; alloc_hdr = '0; fill_valid = '0; fill_tok = '0;
        fill_data = '0; out_ready = 1'b0; flush = 1'b0; det_tag = '0;
    endtask

    task automatic fill(input int p, input logic [3:0] tok, input logic [31:0] d);
        fill_valid[p] = 1'b1;
        fill_tok[p*4 +: 4] = tok;
        fill_data[p*32 +: 32] = d;
    endtask

    initial begin
        logic [3:0] h;
        idle();
        resetn = 1'b0;
        step(); step();
        resetn = 1'b1;
        #1;
        chk("rst_ready", alloc_ready, 1); chk("rst_tok", alloc_tok, 1);
        chk("rst_oval", out_valid, 0);    chk("rst_haz", hazard, 0);
        chk("rst_cnt", count, 0);

        // fill queue with 0x10..0x13
        for (int k = 0; k < 4; k++) begin
            alloc_valid = 1'b1; alloc_hdr = 32'h10 + k;
            #1;
            chk("alloc_tok", alloc_tok, 4'b1 << k); chk("alloc_rdy", alloc_ready, 1);
            step();
        end
        idle(); #1;
        chk("full_cnt", count, 4); chk("full_rdy", alloc_ready, 0); chk("full_oval", out_valid, 0);

        // out-of-order fill, in-order retire with bypass
        out_ready = 1'b1; fill(0, 4'd4, 32'hC); #1;
        chk("ooo_noval", out_valid, 0);
        step(); idle(); out_ready = 1'b1;
        fill(0, 4'd1, 32'hA); #1;
        chk("ooo0_val", out_valid, 1); chk("ooo0_hdr", out_hdr, 32'h10); chk("ooo0_data", out_data, 32'hA);
        step(); idle(); out_ready = 1'b1;
        fill(1, 4'd2, 32'hB); #1;
        chk("ooo1_val", out_valid, 1); chk("ooo1_hdr", out_hdr, 32'h11); chk("ooo1_data", out_data, 32'hB);
        step(); idle(); out_ready = 1'b1; #1;
        chk("ooo2_val", out_valid, 1); chk("ooo2_hdr", out_hdr, 32'h12); chk("ooo2_data", out_data, 32'hC);
        step(); idle(); #1;
        chk("ooo_cnt", count, 1); chk("ooo_noval2", out_valid, 0);

        // hazard: live 0x13 (head, tok 8) and 0x25
        alloc_valid = 1'b1; alloc_hdr = 32'h25; #1;
        chk("haz_tok", alloc_tok, 1);
        step(); idle();
        det_tag = 4'd3; #1; chk("haz_3", hazard, 1);
        det_tag = 4'd5; #1; chk("haz_5", hazard, 1);
        det_tag = 4'd6; #1; chk("haz_6", hazard, 0);
        det_tag = 4'd3; out_ready = 1'b1; fill(0, 4'd8, 32'hD); #1;
        chk("haz_ret", hazard, 0); chk("haz_rval", out_valid, 1); chk("haz_rdata", out_data, 32'hD);
        step(); idle(); det_tag = 4'd3; #1;
        chk("haz_gone", hazard, 0); chk("haz_cnt", count, 1);

        // dual-port conflict on tok 1 (0x25)
        fill(0, 4'd1, 32'h5); fill(1, 4'd1, 32'h6); #1;
        chk("dual_val", out_valid, 1); chk("dual_data", out_data, 32'h5);
        step(); idle();
        fill(0, 4'd1, 32'h7); #1;
        chk("refill_data", out_data, 32'h5);
        step(); idle(); out_ready = 1'b1; #1;
        chk("dual_hdr", out_hdr, 32'h25); chk("dual_data2", out_data, 32'h5);
        step(); idle(); #1;
        chk("dual_empty", count, 0); chk("dual_tok", alloc_tok, 2);

        // refill to full (tokens 2,4,8,1), then 3 laps of full-replace
        for (int k = 0; k < 4; k++) begin
            alloc_valid = 1'b1; alloc_hdr = 32'h20 + k;
            if (k == 3) fill(1, 4'd2, 32'h100);
            step();
        end
        idle();
        for (int n = 0; n < 12; n++) begin
            h = 4'b1 << ((1 + n) % 4);
            alloc_valid = 1'b1; alloc_hdr = 32'h40 + n; out_ready = 1'b1;
            fill(0, {h[2:0], h[3]}, 32'h100 + n + 1);
            #1;
            chk("lap_rdy", alloc_ready, 1);  chk("lap_tok", alloc_tok, h);
            chk("lap_val", out_valid, 1);    chk("lap_cnt", count, 4);
            chk("lap_hdr", out_hdr, (n < 4) ? 32'h20 + n : 32'h40 + n - 4);
            chk("lap_data", out_data, 32'h100 + n);
            step(); idle();
        end
        #1; chk("lap_endcnt", count, 4);

        // flush with alloc and fill pending
        det_tag = 4'd8; #1; chk("pre_flush_haz", hazard, 1);
        flush = 1'b1; alloc_valid = 1'b1; alloc_hdr = 32'h55; out_ready = 1'b1;
        fill(0, 4'd4, 32'hEE); #1;
        chk("fl_oval", out_valid, 0); chk("fl_rdy", alloc_ready, 0);
        step(); idle(); det_tag = 4'd8; #1;
        chk("fl_cnt", count, 0); chk("fl_oval2", out_valid, 0); chk("fl_tok", alloc_tok, 1);
        chk("fl_haz8", hazard, 0);
        det_tag = 4'd5; #1; chk("fl_haz5", hazard, 0);

        // reset mid-stream
        for (int k = 0; k < 2; k++) begin
            alloc_valid = 1'b1; alloc_hdr = 32'h61 + k;
            step();
        end
        idle(); det_tag = 4'd1; #1;
        chk("rs_haz_pre", hazard, 1); chk("rs_cnt_pre", count, 2);
        resetn = 1'b0; alloc_valid = 1'b1; alloc_hdr = 32'h77; out_ready = 1'b1;
        step(); resetn = 1'b1; idle(); det_tag = 4'd1; #1;
        chk("rs_cnt", count, 0); chk("rs_oval", out_valid, 0); chk("rs_tok", alloc_tok, 1);
        chk("rs_haz", hazard, 0); chk("rs_rdy", alloc_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
